// File: rtl/serial_add_pkg.sv
// serial_add_pkg: shared constants, state type and sizing helpers for the
// nibble-serial adder controller. Optional feature macro: SERIAL_ADD_SUB_EN.
package serial_add_pkg;

   localparam int unsigned NIBBLE_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Number of nibble steps needed for a WIDTH-bit operand.
   function automatic int unsigned nib_count(input int unsigned width);
      return width / NIBBLE_W;
   endfunction

   // Width of the nibble counter (at least one bit).
   function automatic int unsigned cnt_width(input int unsigned width);
      int unsigned n;
      n = nib_count(width);
      if (n <= 1) begin
         return 1;
      end
      return $clog2(n);
   endfunction

endpackage

// File: rtl/serial_add_ctrl_if.sv
// serial_add_ctrl_if: requester <-> controller handshake and data bundle.
// sub_i exists only when SERIAL_ADD_SUB_EN is defined.
interface serial_add_ctrl_if #(
   parameter int unsigned WIDTH = 16
) ();

   logic             start_i;
   logic [WIDTH-1:0] a_i;
   logic [WIDTH-1:0] b_i;
`ifdef SERIAL_ADD_SUB_EN
   logic             sub_i;
`endif
   logic             ready_o;
   logic             busy_o;
   logic             valid_o;
   logic             ack_i;
   logic [WIDTH-1:0] sum_o;
   logic             c_o;

   // Requester side.
   modport master (
      output start_i, a_i, b_i, ack_i,
`ifdef SERIAL_ADD_SUB_EN
      output sub_i,
`endif
      input  ready_o, busy_o, valid_o, sum_o, c_o
   );

   // Controller side.
   modport slave (
      input  start_i, a_i, b_i, ack_i,
`ifdef SERIAL_ADD_SUB_EN
      input  sub_i,
`endif
      output ready_o, busy_o, valid_o, sum_o, c_o
   );

endinterface

// File: rtl/serial_add_ctrl_adder_nibble.sv
// adder_nibble: 4-bit ripple-carry adder with carry-in and carry-out; the
// single shared arithmetic stage of the serial adder.
module adder_nibble
   import serial_add_pkg::*;
(
   input  logic [NIBBLE_W-1:0] a_i,
   input  logic [NIBBLE_W-1:0] b_i,
   input  logic                c_i,
   output logic [NIBBLE_W-1:0] s_o,
   output logic                c_o
);

   logic [NIBBLE_W:0] carry;

   // Ripple the carry through one full adder per bit.
   always_comb begin
      carry    = '0;
      s_o      = '0;
      carry[0] = c_i;
      for (int unsigned i = 0; i < NIBBLE_W; i++) begin
         s_o[i]     = a_i[i] ^ b_i[i] ^ carry[i];
         carry[i+1] = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
      end
      c_o = carry[NIBBLE_W];
   end

endmodule

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: adds two WIDTH-bit operands through one shared 4-bit
// adder, least-significant nibble first, latency WIDTH/4 cycles.
// Optional subtract mode when SERIAL_ADD_SUB_EN is defined.
module serial_add_ctrl
   import serial_add_pkg::*;
#(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   serial_add_ctrl_if.slave bus
);

   localparam int unsigned       NIB_CNT  = nib_count(WIDTH);
   localparam int unsigned       CNT_W    = cnt_width(WIDTH);
   localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(NIB_CNT - 1);

   state_t             state_q;
   state_t             state_d;
   logic [WIDTH-1:0]   a_sh;
   logic [WIDTH-1:0]   b_sh;
   logic               carry_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [WIDTH-1:0]   sum_q;
   logic               c_q;
   logic [NIBBLE_W-1:0] nib_sum;
   logic               nib_co;
   logic               sub_sel;
   logic               last_nib;

   // Subtract select; tied off when the feature is not built.
`ifdef SERIAL_ADD_SUB_EN
   always_comb sub_sel = bus.sub_i;
`else
   always_comb sub_sel = 1'b0;
`endif

   // Final nibble of the current operation.
   always_comb last_nib = (cnt_q == LAST_CNT);

   adder_nibble u_adder (
      .a_i (a_sh[NIBBLE_W-1:0]),
      .b_i (b_sh[NIBBLE_W-1:0]),
      .c_i (carry_q),
      .s_o (nib_sum),
      .c_o (nib_co)
   );

   // State register.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; start is only seen in IDLE, ack only in DONE.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (bus.start_i) state_d = RUN;
         RUN:     if (last_nib)    state_d = DONE;
         DONE:    if (bus.ack_i)   state_d = IDLE;
         default:                  state_d = IDLE;
      endcase
   end

   // State-decoded handshake outputs and registered result.
   always_comb begin
      bus.ready_o = (state_q == IDLE);
      bus.busy_o  = (state_q == RUN);
      bus.valid_o = (state_q == DONE);
      bus.sum_o   = sum_q;
      bus.c_o     = c_q;
   end

   // Operand load, nibble shifting, carry chaining and result assembly.
   // Subtraction is a + ~b + 1: B is inverted on load and the carry seeds 1.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         a_sh    <= '0;
         b_sh    <= '0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
         sum_q   <= '0;
         c_q     <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (bus.start_i) begin
                  a_sh    <= bus.a_i;
                  b_sh    <= sub_sel ? ~bus.b_i : bus.b_i;
                  carry_q <= sub_sel;
                  cnt_q   <= '0;
                  sum_q   <= '0;
               end
            end
            RUN: begin
               sum_q   <= {nib_sum, sum_q[WIDTH-1:NIBBLE_W]};
               carry_q <= nib_co;
               a_sh    <= a_sh >> NIBBLE_W;
               b_sh    <= b_sh >> NIBBLE_W;
               cnt_q   <= cnt_q + CNT_W'(1);
               if (last_nib) begin
                  c_q <= nib_co;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl: scoreboard bench for serial_add_ctrl (WIDTH=16).
// Subtract cases are included when SERIAL_ADD_SUB_EN is defined.
module tb_serial_add_ctrl;

   localparam int unsigned W   = 16;
   localparam int unsigned LAT = W / 4;

   typedef struct {
      logic [W-1:0] sum;
      logic         c;
   } exp_t;

   logic clk_i = 1'b0;
   logic rst_i = 1'b1;

   serial_add_ctrl_if #(.WIDTH(W)) bus ();

   serial_add_ctrl #(.WIDTH(W)) dut (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .bus   (bus)
   );

   always #5 clk_i = ~clk_i;

   int   checks   = 0;
   int   failures = 0;
   exp_t sb_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: plain integer arithmetic on the full-width operands.
   function automatic exp_t ref_model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
      exp_t        e;
      logic [W:0]  wide;
      if (s) begin
         e.sum = a - b;
         e.c   = (a >= b);
      end else begin
         wide  = {1'b0, a} + {1'b0, b};
         e.sum = wide[W-1:0];
         e.c   = wide[W];
      end
      return e;
   endfunction

   task automatic drive_sub(input logic s);
`ifdef SERIAL_ADD_SUB_EN
      bus.sub_i = s;
`else
      if (s) $display("note: subtract requested without SERIAL_ADD_SUB_EN");
`endif
   endtask

   // Wait (bounded) for ready, then present one request for one edge.
   task automatic accept(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
      int unsigned n = 0;
      while (!bus.ready_o && n < 100) begin
         @(posedge clk_i); #1;
         n++;
      end
      check("ready_before_start", bus.ready_o, 1);
      bus.start_i = 1'b1;
      bus.a_i     = a;
      bus.b_i     = b;
      drive_sub(s);
      sb_q.push_back(ref_model(a, b, s));
      @(posedge clk_i); #1;
      bus.start_i = 1'b0;
      drive_sub(1'b0);
   endtask

   // Called #1 after the accepting edge; checks RUN window and valid timing.
   task automatic expect_latency();
      check("run_busy", bus.busy_o, 1);
      check("run_ready", bus.ready_o, 0);
      for (int unsigned i = 1; i <= LAT; i++) begin
         @(posedge clk_i); #1;
         if (i < LAT) begin
            check("run_valid_low", bus.valid_o, 0);
            check("run_ready_low", bus.ready_o, 0);
         end else begin
            check("valid_at_latency", bus.valid_o, 1);
            check("busy_done", bus.busy_o, 0);
         end
      end
   endtask

   task automatic ack_it();
      bus.ack_i = 1'b1;
      @(posedge clk_i); #1;
      bus.ack_i = 1'b0;
      check("ack_ready", bus.ready_o, 1);
      check("ack_valid", bus.valid_o, 0);
   endtask

   task automatic full_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                          input int unsigned hold);
      accept(a, b, s);
      expect_latency();
      for (int unsigned i = 0; i < hold; i++) begin
         @(posedge clk_i); #1;
      end
      ack_it();
   endtask

   // Monitor: pop one expectation per rising valid_o and compare.
   initial begin
      logic seen = 1'b0;
      exp_t e;
      forever begin
         @(negedge clk_i);
         if (rst_i) begin
            seen = 1'b0;
         end else if (bus.valid_o && !seen) begin
            seen = 1'b1;
            if (sb_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL sb_unexpected: got sum 0x%0h with no request outstanding, expected none", bus.sum_o);
            end else begin
               e = sb_q.pop_front();
               check("sb_sum", 32'(bus.sum_o), 32'(e.sum));
               check("sb_carry", 32'(bus.c_o), 32'(e.c));
            end
         end else if (!bus.valid_o) begin
            seen = 1'b0;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      exp_t e;
      bus.start_i = 1'b0;
      bus.ack_i   = 1'b0;
      bus.a_i     = '0;
      bus.b_i     = '0;
      drive_sub(1'b0);

      // Reset state.
      repeat (3) @(posedge clk_i);
      #1 rst_i = 1'b0;
      check("rst_ready", bus.ready_o, 1);
      check("rst_busy", bus.busy_o, 0);
      check("rst_valid", bus.valid_o, 0);
      check("rst_sum", 32'(bus.sum_o), 0);
      check("rst_c", bus.c_o, 0);

      // Directed additions, including full carry propagation.
      full_op(16'h1234, 16'h4321, 1'b0, 0);
      full_op(16'hFFFF, 16'h0001, 1'b0, 1);
      full_op(16'h8000, 16'h8000, 1'b0, 0);

      // Start during RUN is dropped; start together with ack in DONE ignored.
      accept(16'h0101, 16'h0202, 1'b0);
      bus.start_i = 1'b1;
      bus.a_i     = 16'hFFFF;
      bus.b_i     = 16'hFFFF;
      @(posedge clk_i); #1;
      bus.start_i = 1'b0;
      repeat (LAT - 1) @(posedge clk_i);
      #1;
      check("drop_valid", bus.valid_o, 1);
      check("drop_sum", 32'(bus.sum_o), 32'h0303);
      bus.ack_i   = 1'b1;
      bus.start_i = 1'b1;
      @(posedge clk_i); #1;
      bus.ack_i   = 1'b0;
      bus.start_i = 1'b0;
      check("ackstart_ready", bus.ready_o, 1);
      check("ackstart_busy", bus.busy_o, 0);
      @(posedge clk_i); #1;
      check("ackstart_idle", bus.ready_o, 1);

      // Result held stable while ack is withheld, then back-to-back request.
      accept(16'hA5C3, 16'h7E19, 1'b0);
      e = ref_model(16'hA5C3, 16'h7E19, 1'b0);
      expect_latency();
      for (int unsigned i = 0; i < 10; i++) begin
         @(posedge clk_i); #1;
         check("hold_valid", bus.valid_o, 1);
         check("hold_sum", 32'(bus.sum_o), 32'(e.sum));
         check("hold_c", bus.c_o, e.c);
      end
      ack_it();
      full_op(16'h0F0F, 16'hF0F1, 1'b0, 0);

      // Reset in the second RUN cycle discards the operation.
      accept(16'h2222, 16'h3333, 1'b0);
      @(posedge clk_i); #1;
      rst_i = 1'b1;
      @(posedge clk_i); #1;
      rst_i = 1'b0;
      sb_q.delete();
      check("midrst_ready", bus.ready_o, 1);
      check("midrst_valid", bus.valid_o, 0);
      check("midrst_sum", 32'(bus.sum_o), 0);
      check("midrst_c", bus.c_o, 0);
      full_op(16'h00FF, 16'h0001, 1'b0, 0);

`ifdef SERIAL_ADD_SUB_EN
      full_op(16'h0005, 16'h0007, 1'b1, 0);
      full_op(16'h0007, 16'h0005, 1'b1, 0);
      full_op(16'h1234, 16'h1234, 1'b1, 0);
`endif

      // Randomized traffic with random ack delays.
      for (int unsigned k = 0; k < 40; k++) begin
         logic [W-1:0] ra;
         logic [W-1:0] rb;
         logic         rs;
         ra = W'($urandom);
         rb = W'($urandom);
         if (k % 8 == 0) ra = '1;
`ifdef SERIAL_ADD_SUB_EN
         rs = 1'($urandom_range(0, 1));
`else
         rs = 1'b0;
`endif
         full_op(ra, rb, rs, $urandom_range(0, 3));
      end

      repeat (3) @(posedge clk_i);
      #1;
      check("sb_drained", sb_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/serial_add_ctrl.md
# serial_add_ctrl

Multi-cycle controller that adds two WIDTH-bit operands by sequencing one shared 4-bit ripple adder stage nibble-by-nibble, least-significant nibble first, with a registered carry between nibbles. It sits between a requester issuing start/operand handshakes and the nibble adder datapath. It trades latency (WIDTH/4 cycles) for a single 4-bit adder instance.

## Interface
- WIDTH, 16, operand/result width; must be a multiple of 4 and at least 8.
- clk_i  in  1  clock; all logic on rising edge.
- rst_i  in  1  reset; synchronous, active-high.
- start_i  in  1  request valid; accepted only when ready_o=1.
- a_i  in  WIDTH  operand A, sampled on the accepting edge.
- b_i  in  WIDTH  operand B, sampled on the accepting edge.
- sub_i  in  1  subtract select, sampled on the accepting edge (present only with SERIAL_ADD_SUB_EN).
- ready_o  out  1  controller idle, can accept start_i.
- busy_o  out  1  nibble sequencing in progress.
- valid_o  out  1  result available; held until ack_i.
- ack_i  in  1  result consumed; honoured only while valid_o=1.
- sum_o  out  WIDTH  registered result.
- c_o  out  1  registered final carry-out.

## Operation
- States: IDLE, RUN, DONE. Reset → IDLE.
- Reset values: ready_o=1, busy_o=0, valid_o=0, sum_o=0, c_o=0; operand shift registers, carry register and nibble counter cleared.
- ready_o = (state==IDLE); busy_o = (state==RUN); valid_o = (state==DONE).
- IDLE & start_i: load a_i/b_i into shift registers, clear carry, clear counter, clear sum_o, go to RUN.
- RUN, each cycle: adder sums the low nibbles of the A and B shift registers plus the carry register. On the edge:
  - the 4-bit sum shifts into sum_o from the MSB end;
  - the carry register takes the nibble carry-out;
  - the operands shift right by 4;
  - the counter increments.
- RUN, last nibble (counter = WIDTH/4-1): c_o takes the final carry; go to DONE.
- DONE: sum_o and c_o held stable. ack_i → IDLE.
- Arithmetic is modulo 2^WIDTH; c_o is bit WIDTH of a+b.
- start_i outside IDLE ignored (no queuing); ack_i outside DONE ignored.
- Simultaneous start_i and ack_i in DONE: ack_i honoured, start_i ignored.
- rst_i overrides everything, including mid-RUN: all state returns to reset values, and the in-flight operation is discarded.

## Timing
- Accept at edge T; RUN occupies cycles T..T+WIDTH/4-1.
- valid_o first high after edge T+WIDTH/4, i.e. latency WIDTH/4 cycles (4 for WIDTH=16).
- ack_i sampled at edge D → ready_o high after D.
- Minimum issue interval: WIDTH/4+2 cycles.
- Nibble adder path is combinational within one cycle; all outputs are registered or state-decoded.

## Configuration
- SERIAL_ADD_SUB_EN defined:
  - sub_i port exists.
  - When sub_i=1 at acceptance: B is inverted as loaded, and the carry register initialises to 1, giving a−b in two's complement.
  - c_o=1 means no borrow (a≥b unsigned).
- SERIAL_ADD_SUB_EN undefined: no sub_i port, add only, initial carry always 0.

## Structure
- Package serial_add_pkg holds:
  - NIBBLE_W=4;
  - state typedef (IDLE, RUN, DONE);
  - helper constant function for nibble count (WIDTH/NIBBLE_W) and counter width.
- One sub-module, adder_nibble: 4-bit ripple adder with carry-in and carry-out, instantiated once as the shared datapath stage.
- FSM, shift registers and counter live in serial_add_ctrl.

## Test plan
- WIDTH=16, a=0x1234, b=0x4321 → sum_o=0x5555, c_o=0; valid_o high exactly 4 cycles after accept; ready_o low throughout.
- a=0xFFFF, b=0x0001 → sum_o=0x0000, c_o=1 (carry propagates through all nibbles); a=0x8000, b=0x8000 → 0x0000, c_o=1.
- Accept a=0x0101, b=0x0202, then pulse start_i with a=0xFFFF, b=0xFFFF during RUN → result 0x0303, c_o=0; second request dropped.
- Hold ack_i=0 for 10 cycles in DONE → sum_o/c_o/valid_o stable. Assert ack_i → ready_o=1 next cycle. Back-to-back request then yields the correct result.
- Assert rst_i in the 2nd RUN cycle → next cycle ready_o=1, valid_o=0, sum_o=0, c_o=0. A fresh request a=0x00FF, b=0x0001 → 0x0100, c_o=0.
- With SERIAL_ADD_SUB_EN:
  - sub_i=1, a=0x0005, b=0x0007 → sum_o=0xFFFE, c_o=0.
  - sub_i=1, a=0x0007, b=0x0005 → 0x0002, c_o=1.
